// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, sequencer state encoding and opcode-class helpers.
package cpu_pkg;

    localparam logic [5:0] OP_LW    = 6'd12;
    localparam logic [5:0] OP_SW    = 6'd13;
    localparam logic [5:0] OP_BR_LO = 6'd14;
    localparam logic [5:0] OP_BR_HI = 6'd19;
    localparam logic [5:0] OP_J     = 6'd20;
    localparam logic [5:0] OP_JR    = 6'd21;
    localparam logic [5:0] OP_JAL   = 6'd22;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } seq_state_t;

    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op >= OP_BR_LO) && (op <= OP_BR_HI);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Memory handshakes, control-unit strobes and architectural outputs of the sequencer.
interface instr_sequencer_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic            cu_branch;
    logic            cu_we;
    logic            cu_dmem_we;
    logic [31:0]     cu_offset;
    logic            alu_cond;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;
    logic            reg_we;
    logic [PC_W-1:0] link_val;
    logic [PC_W-1:0] pc;
    logic            halted;

    modport master (
        output imem_req, imem_addr, instr, dmem_req, dmem_we, reg_we, link_val, pc, halted,
        input  imem_ack, imem_rdata, cu_branch, cu_we, cu_dmem_we, cu_offset, alu_cond, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, instr, dmem_req, dmem_we, reg_we, link_val, pc, halted,
        output imem_ack, imem_rdata, cu_branch, cu_we, cu_dmem_we, cu_offset, alu_cond, dmem_ack
    );
endinterface

// File: rtl/instr_sequencer_pc_next_calc.sv
// Combinational next-PC: sequential increment plus the control-transfer target resolved in EXEC.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [5:0]      op_i,
    input  logic [31:0]     offset_i,
    input  logic            cond_i,
    output logic [PC_W-1:0] pc_inc_o,
    output logic [PC_W-1:0] exec_pc_o
);
    logic [PC_W-1:0] br_off;

    assign pc_inc_o = pc_i + PC_W'(1);
    assign br_off   = PC_W'($signed(offset_i[20:0]));

    always_comb begin
        exec_pc_o = pc_inc_o;
        if (is_cond_branch(op_i)) begin
            if (cond_i) begin
                exec_pc_o = pc_inc_o + br_off;
            end
        end else if ((op_i == OP_J) || (op_i == OP_JAL)) begin
            // Jumps replace only the low 26 bits; the upper region of pc is kept.
            exec_pc_o       = pc_i;
            exec_pc_o[25:0] = offset_i[25:0];
        end else if (op_i == OP_JR) begin
            exec_pc_o = offset_i[PC_W-1:0];
        end
    end
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer owning pc and the instruction register.
// Waits indefinitely on imem/dmem acks; rst aborts any outstanding access.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [5:0]      HALT_OP  = 6'd63
) (
    input logic               clk,
    input logic               rst,
    instr_sequencer_if.master bus
);
    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] link_q, link_d;
    logic [PC_W-1:0] pc_inc, exec_pc;
    logic [5:0]      op;
    logic            unused_cu_branch;

    assign op               = instr_q[31:26];
    assign unused_cu_branch = bus.cu_branch;

    pc_next_calc #(.PC_W(PC_W)) u_pc_next (
        .pc_i      (pc_q),
        .op_i      (op),
        .offset_i  (bus.cu_offset),
        .cond_i    (bus.alu_cond),
        .pc_inc_o  (pc_inc),
        .exec_pc_o (exec_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            link_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            link_q  <= link_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        link_d  = link_q;
        unique case (state_q)
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                link_d  = pc_inc;
                state_d = (op == HALT_OP) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if ((op == OP_LW) || (op == OP_SW)) begin
                    state_d = ST_MEM;
                end else if (is_cond_branch(op) || (op == OP_J) || (op == OP_JR)) begin
                    pc_d    = exec_pc;
                    state_d = ST_FETCH;
                end else if (op == OP_JAL) begin
                    pc_d    = exec_pc;
                    state_d = ST_WB;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (bus.dmem_ack) begin
                    if (op == OP_SW) begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                // jal already redirected pc in EXEC.
                if (op != OP_JAL) begin
                    pc_d = pc_inc;
                end
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    assign bus.imem_req  = (state_q == ST_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.instr     = instr_q;
    assign bus.dmem_req  = (state_q == ST_MEM);
    assign bus.dmem_we   = (state_q == ST_MEM) && bus.cu_dmem_we;
    assign bus.reg_we    = (state_q == ST_WB) && bus.cu_we;
    assign bus.link_val  = link_q;
    assign bus.pc        = pc_q;
    assign bus.halted    = (state_q == ST_HALT);
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed and random instruction streams checked against an instruction-level reference model.
module tb_instr_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_sequencer_if #(.PC_W(32)) bus();

    instr_sequencer #(.PC_W(32), .RESET_PC(32'h0), .HALT_OP(6'd63)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference: resulting pc, cycle count, write pulses, data-memory cycles.
    task automatic model(input logic [31:0] iw, input logic [31:0] pc, input logic [31:0] off,
                         input logic cond, input logic we, input int dw,
                         output logic [31:0] npc, output int lat, output int nrw,
                         output int ndm, output logic halt);
        int op;
        int o;
        op   = int'(iw[31:26]);
        npc  = pc + 32'd1;
        lat  = 4;
        nrw  = we ? 1 : 0;
        ndm  = 0;
        halt = 1'b0;
        if (op == 63) begin
            npc = pc; lat = 2; nrw = 0; halt = 1'b1;
        end else if (op == 12) begin
            lat = 5 + dw; ndm = dw + 1;
        end else if (op == 13) begin
            lat = 4 + dw; ndm = dw + 1; nrw = 0;
        end else if (op >= 14 && op <= 19) begin
            o = int'(off[20:0]);
            if (o >= (1 << 20)) o = o - (1 << 21);
            if (cond) npc = pc + 32'd1 + 32'(o);
            lat = 3; nrw = 0;
        end else if (op == 20) begin
            npc = (pc & 32'hFC00_0000) | (off & 32'h03FF_FFFF); lat = 3; nrw = 0;
        end else if (op == 21) begin
            npc = off; lat = 3; nrw = 0;
        end else if (op == 22) begin
            npc = (pc & 32'hFC00_0000) | (off & 32'h03FF_FFFF);
        end
    endtask

    task automatic run_instr(input logic [31:0] iw, input logic we, input logic [31:0] off,
                             input logic cond, input int iwait, input int dwait);
        logic [31:0] npc, start_pc;
        int          lat, nrw, ndm, cyc, rw, dm;
        logic        halt, dwe;
        logic [5:0]  op;
        op             = iw[31:26];
        dwe            = (op == 6'd13);
        start_pc       = exp_pc;
        bus.cu_we      = we;
        bus.cu_dmem_we = dwe;
        bus.cu_offset  = off;
        bus.alu_cond   = cond;
        bus.cu_branch  = (op >= 6'd14) && (op <= 6'd22);
        model(iw, start_pc, off, cond, we, dwait, npc, lat, nrw, ndm, halt);
        chk("fetch_addr", {32'h0, bus.imem_addr}, {32'h0, start_pc});
        repeat (iwait) @(negedge clk);
        chk("fetch_req_held", {63'h0, bus.imem_req}, 64'd1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = iw;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        chk("instr_reg", {32'h0, bus.instr}, {32'h0, iw});
        cyc = 1; rw = 0; dm = 0;
        while (!bus.imem_req && !bus.halted && cyc < 64) begin
            cyc++;
            if (bus.reg_we) rw++;
            if (bus.dmem_req) begin
                chk("dmem_we", {63'h0, bus.dmem_we}, {63'h0, dwe});
                bus.dmem_ack = (dm == dwait);
                dm++;
            end else begin
                bus.dmem_ack = 1'b0;
            end
            @(negedge clk);
        end
        bus.dmem_ack = 1'b0;
        chk("latency", 64'(cyc), 64'(lat));
        chk("reg_we_pulses", 64'(rw), 64'(nrw));
        chk("dmem_cycles", 64'(dm), 64'(ndm));
        chk("pc", {32'h0, bus.pc}, {32'h0, npc});
        chk("halted", {63'h0, bus.halted}, {63'h0, halt});
        if (op == 6'd22) chk("link_val", {32'h0, bus.link_val}, {32'h0, start_pc + 32'd1});
        exp_pc = npc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0;
    endtask

    initial begin
        int          nfetch;
        logic [31:0] hold_pc;
        logic [5:0]  rop;
        rst = 1'b1;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.cu_branch = 1'b0; bus.cu_we = 1'b0;
        bus.cu_dmem_we = 1'b0; bus.cu_offset = '0; bus.alu_cond = 1'b0; bus.dmem_ack = 1'b0;
        exp_pc = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_pc", {32'h0, bus.pc}, 64'h0);
        chk("rst_instr", {32'h0, bus.instr}, 64'h0);
        chk("rst_imem_req", {63'h0, bus.imem_req}, 64'd1);
        chk("rst_strobes", {61'h0, bus.dmem_req, bus.reg_we, bus.halted}, 64'h0);

        run_instr(32'h0022_1820, 1'b1, 32'h0, 1'b0, 0, 0);         // ALU add at pc 0
        run_instr(32'h3001_0004, 1'b1, 32'h4, 1'b0, 1, 3);         // load, slow dmem
        run_instr(32'h5400_0000, 1'b1, 32'd10, 1'b0, 0, 0);        // jr 10, cu_we ignored
        run_instr(32'h3800_0000, 1'b1, 32'h001F_FFFC, 1'b1, 0, 0); // branch taken -> 7
        run_instr(32'h5400_0000, 1'b0, 32'd10, 1'b0, 0, 0);
        run_instr(32'h3800_0000, 1'b0, 32'h001F_FFFC, 1'b0, 2, 0); // branch not taken -> 11
        run_instr(32'h5400_0000, 1'b0, 32'h0400_0005, 1'b0, 0, 0);
        run_instr(32'h5800_0100, 1'b1, 32'h0000_0100, 1'b0, 0, 0); // jal
        run_instr(32'h5400_0000, 1'b1, 32'h0000_0040, 1'b0, 0, 0); // jr 0x40
        run_instr(32'h3400_0000, 1'b0, 32'h0, 1'b0, 0, 2);         // store, slow dmem
        run_instr(32'h5400_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 0, 0);
        run_instr(32'h0000_0000, 1'b1, 32'h0, 1'b0, 0, 0);         // pc wraps to 0

        for (int i = 0; i < 40; i++) begin
            rop = 6'($urandom_range(0, 62));
            run_instr({rop, 26'($urandom)}, 1'($urandom), $urandom, 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a stalled store; a late dmem_ack must be ignored.
        bus.cu_dmem_we = 1'b1; bus.cu_we = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3400_0000;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        nfetch = 0;
        while (!bus.dmem_req && nfetch < 10) begin
            nfetch++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("store_stalled", {62'h0, bus.dmem_req, bus.dmem_we}, 64'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0;
        chk("rst_mid_pc", {32'h0, bus.pc}, 64'h0);
        chk("rst_mid_fetch", {62'h0, bus.imem_req, bus.dmem_req}, 64'd2);
        bus.dmem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_ignored", {30'h0, bus.imem_req, bus.dmem_req, bus.pc}, {30'h0, 2'b10, 32'h0});
        end
        bus.dmem_ack = 1'b0;

        run_instr(32'h0000_0000, 1'b1, 32'h0, 1'b0, 0, 0);
        run_instr(32'hFC00_0000, 1'b1, 32'h0, 1'b0, 1, 0);         // halt
        hold_pc = exp_pc;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0;
        repeat (4) begin
            @(negedge clk);
            chk("halt_frozen", {29'h0, bus.halted, bus.imem_req, bus.dmem_req, bus.pc},
                {29'h0, 3'b100, hold_pc});
        end
        bus.imem_ack = 1'b0;
        do_reset();
        chk("halt_exit", {30'h0, bus.halted, bus.imem_req, bus.pc}, {30'h0, 2'b01, 32'h0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
